// File: rtl/loop_filter_pkg.sv
// Shared types for the PLL loop-filter K-counter control path.
//   gear_t        : K-counter modulus select (K = 8, 16, 32, 64)
//   ctrl_state_t  : gear controller FSM states
//   gear_modulus  : K value selected by a gear
package loop_filter_pkg;

   typedef enum logic [1:0] {
      GEAR_K8  = 2'd0,
      GEAR_K16 = 2'd1,
      GEAR_K32 = 2'd2,
      GEAR_K64 = 2'd3
   } gear_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } ctrl_state_t;

   // K modulus for a gear: 8 << gear
   function automatic int unsigned gear_modulus(input gear_t gear);
      return 32'd8 << 2'(gear);
   endfunction

endpackage

// File: rtl/trigger_window_counter.sv
// Observation-window timer and saturating K-counter trigger counter.
// Ports:
//   clk_i, reset_i    clock, async active-low reset
//   run_i             window running; low clears timer and count
//   trigger_i         K counter reached +K or -K this cycle
//   windowEnd_c       current cycle is the last cycle of the window
//   triggerCount_c    trigger count of the window including this cycle
//   quiet_c, slip_c   window-end classification of the closing window
module trigger_window_counter #(
   parameter int unsigned WINDOW_CYCLES = 256,
   parameter int unsigned QUIET_MAX     = 2,
   parameter int unsigned SLIP_MIN      = 16
) (
   input  logic                                clk_i,
   input  logic                                reset_i,
   input  logic                                run_i,
   input  logic                                trigger_i,
   output logic                                windowEnd_c,
   output logic [$clog2(SLIP_MIN + 1)-1:0]     triggerCount_c,
   output logic                                quiet_c,
   output logic                                slip_c
);

   localparam int unsigned TIMER_W = $clog2(WINDOW_CYCLES);
   localparam int unsigned COUNT_W = $clog2(SLIP_MIN + 1);

   logic [TIMER_W-1:0] timer_q;
   logic [COUNT_W-1:0] count_q;
   logic [COUNT_W-1:0] count_c;

   // Running count including this cycle's trigger, saturating at SLIP_MIN
   always_comb begin
      count_c = count_q;
      if (run_i && trigger_i && (count_q != COUNT_W'(SLIP_MIN))) begin
         count_c = count_q + COUNT_W'(1);
      end
   end

   assign windowEnd_c    = run_i && (timer_q == TIMER_W'(WINDOW_CYCLES - 1));
   assign triggerCount_c = count_c;
   assign quiet_c        = windowEnd_c && (count_c <= COUNT_W'(QUIET_MAX));
   assign slip_c         = windowEnd_c && (count_c >= COUNT_W'(SLIP_MIN));

   // Timer wraps at the window end; the count restarts for the next window
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         timer_q <= '0;
         count_q <= '0;
      end else if (!run_i) begin
         timer_q <= '0;
         count_q <= '0;
      end else if (windowEnd_c) begin
         timer_q <= '0;
         count_q <= '0;
      end else begin
         timer_q <= timer_q + TIMER_W'(1);
         count_q <= count_c;
      end
   end

endmodule

// File: rtl/kcounter_gear_ctrl.sv
// Gear-shifting controller for the loop-filter reversible K counter.
// Steers the counter up/down from the phase error, classifies each
// observation window by its trigger count and shifts the K modulus:
// quiet windows shift up one gear, a slip window drops back to K=8.
// reset_i is expected to be release-synchronised upstream.
// Ports:
//   clk_i, reset_i                 clock, async active-low reset
//   enable_i                       loop enable; low returns to IDLE
//   phaseErr_i                     XOR phase detector, 1 = count up
//   triggeredMax_i/triggeredMin_i  K counter reached +K / -K
//   increment_o/decrement_o        K counter step controls (combinational)
//   gear_o                         modulus select 0..3 -> K = 8..64
//   loadCounter_o                  one-cycle reload pulse
//   initialValue_o                 reload value (always 0)
//   locked_o                       loop locked
module kcounter_gear_ctrl
   import loop_filter_pkg::*;
#(
   parameter int unsigned WIDTH         = 7,
   parameter int unsigned WINDOW_CYCLES = 256,
   parameter int unsigned QUIET_MAX     = 2,
   parameter int unsigned QUIET_WINDOWS = 4,
   parameter int unsigned SLIP_MIN      = 16
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             enable_i,
   input  logic             phaseErr_i,
   input  logic             triggeredMax_i,
   input  logic             triggeredMin_i,
   output logic             increment_o,
   output logic             decrement_o,
   output logic [1:0]       gear_o,
   output logic             loadCounter_o,
   output logic [WIDTH-1:0] initialValue_o,
   output logic             locked_o
);

   localparam int unsigned QCNT_W = $clog2(QUIET_WINDOWS + 1);
   localparam int unsigned CNT_W  = $clog2(SLIP_MIN + 1);

   ctrl_state_t        state_q, state_d;
   gear_t              gear_q, gear_d;
   logic [QCNT_W-1:0]  quiet_q, quiet_d;
   logic               load_q, load_d;
   logic               locked_q, locked_d;

   logic               run;
   logic               window_end;
   logic [CNT_W-1:0]   trigger_count;
   logic               quiet;
   logic               slip;

   // Window machinery only runs while the loop is active and stays enabled
   assign run = enable_i && (state_q != IDLE);

   trigger_window_counter #(
      .WINDOW_CYCLES (WINDOW_CYCLES),
      .QUIET_MAX     (QUIET_MAX),
      .SLIP_MIN      (SLIP_MIN)
   ) u_trigger_window_counter (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .run_i          (run),
      .trigger_i      (triggeredMax_i | triggeredMin_i),
      .windowEnd_c    (window_end),
      .triggerCount_c (trigger_count),
      .quiet_c        (quiet),
      .slip_c         (slip)
   );

   // State register
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q  <= IDLE;
         gear_q   <= GEAR_K8;
         quiet_q  <= '0;
         load_q   <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         gear_q   <= gear_d;
         quiet_q  <= quiet_d;
         load_q   <= load_d;
         locked_q <= locked_d;
      end
   end

   // Next-state and window-end gear decision
   always_comb begin
      state_d = state_q;
      gear_d  = gear_q;
      quiet_d = quiet_q;
      load_d  = 1'b0;

      if (!enable_i) begin
         state_d = IDLE;
         gear_d  = GEAR_K8;
         quiet_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = ACQUIRE;
            end
            ACQUIRE, LOCKED: begin
               if (window_end) begin
                  if (slip) begin
                     state_d = ACQUIRE;
                     gear_d  = GEAR_K8;
                     quiet_d = '0;
                     load_d  = (gear_q != GEAR_K8);
                  end else if (quiet) begin
                     if (quiet_q < QCNT_W'(QUIET_WINDOWS - 1)) begin
                        quiet_d = quiet_q + QCNT_W'(1);
                     end else if (state_q == LOCKED) begin
                        quiet_d = QCNT_W'(QUIET_WINDOWS);
                     end else if (gear_q != GEAR_K64) begin
                        gear_d  = gear_t'(gear_q + 2'd1);
                        load_d  = 1'b1;
                        quiet_d = '0;
                     end else begin
                        // Top gear held quiet long enough: declare lock, keep K
                        state_d = LOCKED;
                        quiet_d = QCNT_W'(QUIET_WINDOWS);
                     end
                  end else begin
                     quiet_d = '0;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               gear_d  = GEAR_K8;
               quiet_d = '0;
            end
         endcase
      end
   end

   assign locked_d = (state_d == LOCKED);

   // Counter steering is suppressed while idle and during the reload cycle
   assign increment_o    = (state_q != IDLE) && !load_q &&  phaseErr_i;
   assign decrement_o    = (state_q != IDLE) && !load_q && !phaseErr_i;
   assign gear_o         = gear_q;
   assign loadCounter_o  = load_q;
   assign initialValue_o = '0;
   assign locked_o       = locked_q;

   count_in_range_a: assert property (@(posedge clk_i) disable iff (!reset_i)
      (trigger_count <= CNT_W'(SLIP_MIN)) && !(quiet && slip));

endmodule
